// File: rtl/mem_bus_arbiter_if.sv
// Bundles the two master ports and the external buffer-side signals of mem_bus_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory side.
interface mem_bus_arbiter_if;
    logic        c_req;
    logic        c_wr;
    logic        c_byte;
    logic [15:0] c_addr;
    logic [15:0] c_dout;
    logic [15:0] c_din;
    logic        c_ack;

    logic        d_req;
    logic        d_wr;
    logic        d_byte;
    logic [15:0] d_addr;
    logic [15:0] d_dout;
    logic [15:0] d_din;
    logic        d_ack;

    logic        gnt_d;
    logic [15:0] addr_buf;
    logic [15:0] dout_buf;
    logic [15:0] din;
    logic        rdn_buf;
    logic        wrn0_buf;
    logic        wrn1_buf;
    logic        abus_oen;

    modport slave (
        input  c_req, c_wr, c_byte, c_addr, c_dout,
        input  d_req, d_wr, d_byte, d_addr, d_dout,
        input  din,
        output c_din, c_ack, d_din, d_ack,
        output gnt_d, addr_buf, dout_buf, rdn_buf, wrn0_buf, wrn1_buf, abus_oen
    );

    modport master (
        output c_req, c_wr, c_byte, c_addr, c_dout,
        output d_req, d_wr, d_byte, d_addr, d_dout,
        output din,
        input  c_din, c_ack, d_din, d_ack,
        input  gnt_d, addr_buf, dout_buf, rdn_buf, wrn0_buf, wrn1_buf, abus_oen
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter and IDLE/SETUP/STROBE/DONE sequencer for the external 16-bit memory bus.
// Define MEMARB_FAIRNESS_EN to let port D win after STARVE_LIMIT consecutive core grants.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst,
    mem_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic        owner_d;
    logic        bus_wr;
    logic        bus_byte;
    logic [15:0] addr_q;
    logic [15:0] dout_q;
    logic [15:0] c_din_q;
    logic [15:0] d_din_q;
    logic [3:0]  wait_cnt;

    logic        start;
    logic        pick_d;
    logic        last_strobe;
    logic        rdn;
    logic        wrn0;
    logic        wrn1;
    logic        oen;
    logic        sel_wr;
    logic        sel_byte;
    logic [15:0] sel_addr;
    logic [15:0] sel_dout;
    logic [15:0] lane_din;

    assign start = (state == IDLE) && (bus.c_req || bus.d_req);

`ifdef MEMARB_FAIRNESS_EN
    logic [3:0] starve_cnt;

    assign pick_d = bus.d_req && (!bus.c_req || (starve_cnt == 4'(STARVE_LIMIT)));

    // Counts core grants that were made over a waiting D request
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (start) begin
            if (pick_d)
                starve_cnt <= 4'd0;
            else if (bus.d_req)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign pick_d = bus.d_req && !bus.c_req;
`endif

    always_comb begin
        sel_wr   = bus.c_wr;
        sel_byte = bus.c_byte;
        sel_addr = bus.c_addr;
        sel_dout = bus.c_dout;
        if (pick_d) begin
            sel_wr   = bus.d_wr;
            sel_byte = bus.d_byte;
            sel_addr = bus.d_addr;
            sel_dout = bus.d_dout;
        end
    end

    always_comb begin
        lane_din = bus.din;
        if (bus_byte)
            lane_din = addr_q[0] ? {8'h00, bus.din[15:8]} : {8'h00, bus.din[7:0]};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Strobes are only ever asserted in STROBE, so address is settled around them
    always_comb begin
        next_state  = state;
        rdn         = 1'b1;
        wrn0        = 1'b1;
        wrn1        = 1'b1;
        oen         = 1'b1;
        last_strobe = 1'b0;
        case (state)
            IDLE: begin
                if (bus.c_req || bus.d_req)
                    next_state = SETUP;
            end
            SETUP: begin
                oen        = 1'b0;
                next_state = STROBE;
            end
            STROBE: begin
                oen = 1'b0;
                if (!bus_wr) begin
                    rdn = 1'b0;
                end else if (!bus_byte) begin
                    wrn0 = 1'b0;
                    wrn1 = 1'b0;
                end else if (addr_q[0]) begin
                    wrn1 = 1'b0;
                end else begin
                    wrn0 = 1'b0;
                end
                if (wait_cnt == 4'(WAIT_STATES)) begin
                    last_strobe = 1'b1;
                    next_state  = DONE;
                end
            end
            DONE: begin
                oen        = 1'b0;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus registers are latched at grant time with write-lane steering already applied
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d  <= 1'b0;
            bus_wr   <= 1'b0;
            bus_byte <= 1'b0;
            addr_q   <= 16'h0000;
            dout_q   <= 16'h0000;
            wait_cnt <= 4'd0;
            c_din_q  <= 16'h0000;
            d_din_q  <= 16'h0000;
        end else begin
            if (start) begin
                owner_d  <= pick_d;
                bus_wr   <= sel_wr;
                bus_byte <= sel_byte;
                addr_q   <= sel_addr;
                if (sel_byte)
                    dout_q <= sel_addr[0] ? {sel_dout[7:0], 8'h00} : {8'h00, sel_dout[7:0]};
                else
                    dout_q <= sel_dout;
            end
            if (state == STROBE)
                wait_cnt <= wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;
            if (last_strobe) begin
                if (owner_d)
                    d_din_q <= lane_din;
                else
                    c_din_q <= lane_din;
            end
        end
    end

    assign bus.addr_buf = addr_q;
    assign bus.dout_buf = dout_q;
    assign bus.rdn_buf  = rdn;
    assign bus.wrn0_buf = wrn0;
    assign bus.wrn1_buf = wrn1;
    assign bus.abus_oen = oen;
    assign bus.c_din    = c_din_q;
    assign bus.d_din    = d_din_q;
    assign bus.c_ack    = (state == DONE) && !owner_d;
    assign bus.d_ack    = (state == DONE) && owner_d;
    assign bus.gnt_d    = (state != IDLE) && owner_d;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter using three instances (WAIT_STATES 0, 2, 3).
// Expected results are queued when an access is issued and popped when its ACK appears.
module tb_mem_bus_arbiter;

    typedef struct {
        logic        is_d;
        logic [15:0] addr;
        logic [15:0] dout;
        logic [15:0] din;
        int          w0_low;
        int          w1_low;
        int          rd_low;
        int          ack_cyc;
    } exp_t;

    exp_t sb[$];

    logic clk;
    logic rst;
    logic rst3;
    int   n_pass;
    int   n_total;

    mem_bus_arbiter_if b0();
    mem_bus_arbiter_if b2();
    mem_bus_arbiter_if b3();

    mem_bus_arbiter #(.WAIT_STATES(0), .STARVE_LIMIT(4)) u0 (.clk(clk), .rst(rst),  .bus(b0));
    mem_bus_arbiter #(.WAIT_STATES(2), .STARVE_LIMIT(4)) u2 (.clk(clk), .rst(rst),  .bus(b2));
    mem_bus_arbiter #(.WAIT_STATES(3), .STARVE_LIMIT(4)) u3 (.clk(clk), .rst(rst3), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one core access on the WAIT_STATES=0 instance and measures what the bus did
    task automatic core_access(input logic wr, input logic byt, input logic [15:0] addr,
                               input logic [15:0] dout, input logic [15:0] din_val,
                               output int ack_cyc, output int w0, output int w1, output int rd,
                               output logic [15:0] a_seen, output logic [15:0] d_seen,
                               output logic [15:0] cdin);
        b0.c_req  = 1'b1;
        b0.c_wr   = wr;
        b0.c_byte = byt;
        b0.c_addr = addr;
        b0.c_dout = dout;
        b0.din    = din_val;
        ack_cyc = -1;
        w0 = 0; w1 = 0; rd = 0;
        a_seen = 16'hdead; d_seen = 16'hdead; cdin = 16'hdead;
        for (int cyc = 1; cyc <= 20 && ack_cyc < 0; cyc++) begin
            tick();
            if (!b0.wrn0_buf) w0++;
            if (!b0.wrn1_buf) w1++;
            if (!b0.rdn_buf)  rd++;
            if (!b0.rdn_buf || !b0.wrn0_buf || !b0.wrn1_buf) begin
                a_seen = b0.addr_buf;
                d_seen = b0.dout_buf;
            end
            if (b0.c_ack) begin
                ack_cyc = cyc;
                cdin    = b0.c_din;
            end
        end
        b0.c_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [5:0] strobes;
        rst = 1'b1;
        rst3 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rst3 = 1'b0;
        strobes = {b0.rdn_buf, b0.wrn0_buf, b0.wrn1_buf, b0.abus_oen, b0.c_ack, b0.d_ack};
        n_total++;
        if (strobes !== 6'b111100) $display("[TB] FAIL reset_ctrl: got %b want 111100", strobes);
        else n_pass++;
        n_total++;
        if ({b0.addr_buf, b0.dout_buf} !== 32'h0) $display("[TB] FAIL reset_bus: got %h want 0", {b0.addr_buf, b0.dout_buf});
        else n_pass++;
        n_total++;
        if ({b0.c_din, b0.d_din, b0.gnt_d} !== 33'h0) $display("[TB] FAIL reset_din_gnt: got %h want 0", {b0.c_din, b0.d_din, b0.gnt_d});
        else n_pass++;
    endtask

    task automatic run_core_case(input string name, input logic wr, input logic byt,
                                 input logic [15:0] addr, input logic [15:0] dout,
                                 input logic [15:0] din_val, input exp_t e);
        int ack_cyc, w0, w1, rd;
        logic [15:0] a_seen, d_seen, cdin;
        exp_t got;
        sb.push_back(e);
        core_access(wr, byt, addr, dout, din_val, ack_cyc, w0, w1, rd, a_seen, d_seen, cdin);
        got = sb.pop_front();
        n_total++;
        if (ack_cyc !== got.ack_cyc) $display("[TB] FAIL %s_ack_cycle: got %0d want %0d", name, ack_cyc, got.ack_cyc);
        else n_pass++;
        n_total++;
        if ({w0, w1, rd} !== {got.w0_low, got.w1_low, got.rd_low})
            $display("[TB] FAIL %s_strobes: got w0=%0d w1=%0d rd=%0d want w0=%0d w1=%0d rd=%0d", name, w0, w1, rd, got.w0_low, got.w1_low, got.rd_low);
        else n_pass++;
        n_total++;
        if (a_seen !== got.addr) $display("[TB] FAIL %s_addr: got %h want %h", name, a_seen, got.addr);
        else n_pass++;
        if (wr) begin
            n_total++;
            if (d_seen !== got.dout) $display("[TB] FAIL %s_dout: got %h want %h", name, d_seen, got.dout);
            else n_pass++;
        end else begin
            n_total++;
            if (cdin !== got.din) $display("[TB] FAIL %s_cdin: got %h want %h", name, cdin, got.din);
            else n_pass++;
        end
    endtask

    task automatic test_word_write();
        run_core_case("word_wr", 1'b1, 1'b0, 16'hfaaf, 16'hffaf, 16'h0000,
                      '{1'b0, 16'hfaaf, 16'hffaf, 16'h0000, 1, 1, 0, 3});
    endtask

    task automatic test_byte_store();
        run_core_case("bst_hi", 1'b1, 1'b1, 16'h1001, 16'h0035, 16'h0000,
                      '{1'b0, 16'h1001, 16'h3500, 16'h0000, 0, 1, 0, 3});
        run_core_case("bst_lo", 1'b1, 1'b1, 16'h1000, 16'h0035, 16'h0000,
                      '{1'b0, 16'h1000, 16'h0035, 16'h0000, 1, 0, 0, 3});
    endtask

    task automatic test_byte_load();
        run_core_case("bld_hi", 1'b0, 1'b1, 16'h1001, 16'h0000, 16'h3579,
                      '{1'b0, 16'h1001, 16'h0000, 16'h0035, 0, 0, 1, 3});
        run_core_case("bld_lo", 1'b0, 1'b1, 16'h1000, 16'h0000, 16'h3579,
                      '{1'b0, 16'h1000, 16'h0000, 16'h0079, 0, 0, 1, 3});
        run_core_case("wld", 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h3579,
                      '{1'b0, 16'h1000, 16'h0000, 16'h3579, 0, 0, 1, 3});
    endtask

    task automatic test_wait_read();
        int ack_cyc, rd, gnt, c_acks;
        logic [15:0] ddin, cdin_before;
        exp_t got;
        sb.push_back('{1'b1, 16'h0024, 16'h0000, 16'hbeef, 0, 0, 3, 5});
        cdin_before = b2.c_din;
        b2.d_req = 1'b1; b2.d_wr = 1'b0; b2.d_byte = 1'b0; b2.d_addr = 16'h0024; b2.din = 16'hbeef;
        ack_cyc = -1; rd = 0; gnt = 0; c_acks = 0; ddin = 16'hdead;
        for (int cyc = 1; cyc <= 20 && ack_cyc < 0; cyc++) begin
            tick();
            if (!b2.rdn_buf) rd++;
            if (b2.gnt_d) gnt++;
            if (b2.c_ack) c_acks++;
            if (b2.d_ack) begin
                ack_cyc = cyc;
                ddin    = b2.d_din;
            end
        end
        b2.d_req = 1'b0;
        tick();
        got = sb.pop_front();
        n_total++;
        if (ack_cyc !== got.ack_cyc) $display("[TB] FAIL ws2_ack_cycle: got %0d want %0d", ack_cyc, got.ack_cyc);
        else n_pass++;
        n_total++;
        if (rd !== got.rd_low) $display("[TB] FAIL ws2_rdn_low: got %0d want %0d", rd, got.rd_low);
        else n_pass++;
        n_total++;
        if (gnt !== 5) $display("[TB] FAIL ws2_gnt_d_cycles: got %0d want 5", gnt);
        else n_pass++;
        n_total++;
        if (ddin !== got.din) $display("[TB] FAIL ws2_d_din: got %h want %h", ddin, got.din);
        else n_pass++;
        n_total++;
        if ({c_acks, b2.c_din} !== {32'd0, cdin_before}) $display("[TB] FAIL ws2_core_idle: got acks=%0d din=%h want 0 %h", c_acks, b2.c_din, cdin_before);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        int    n_ack;
        logic  grant;
        exp_t  got;
        for (int i = 0; i < 10; i++) begin
`ifdef MEMARB_FAIRNESS_EN
            sb.push_back('{(i % 5) == 4, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0});
`else
            sb.push_back('{1'b0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0});
`endif
        end
        b0.c_wr = 1'b1; b0.c_byte = 1'b0; b0.c_addr = 16'h0100; b0.c_dout = 16'h1111;
        b0.d_wr = 1'b1; b0.d_byte = 1'b0; b0.d_addr = 16'h0200; b0.d_dout = 16'h2222;
        b0.c_req = 1'b1;
        b0.d_req = 1'b1;
        n_ack = 0;
        for (int cyc = 0; cyc < 200 && n_ack < 10; cyc++) begin
            tick();
            if (b0.c_ack || b0.d_ack) begin
                grant = b0.d_ack;
                got   = sb.pop_front();
                n_total++;
                if (grant !== got.is_d) $display("[TB] FAIL arb_grant%0d: got %s want %s", n_ack, grant ? "D" : "C", got.is_d ? "D" : "C");
                else n_pass++;
                n_ack++;
            end
        end
        b0.c_req = 1'b0;
        b0.d_req = 1'b0;
        tick();
        tick();
        n_total++;
        if (n_ack !== 10) $display("[TB] FAIL arb_ack_count: got %0d want 10", n_ack);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_reset_abort();
        int ack_cyc, acks;
        logic [3:0] ctrl;
        logic [15:0] cdin;
        b3.c_req = 1'b1; b3.c_wr = 1'b0; b3.c_byte = 1'b0; b3.c_addr = 16'h0010; b3.din = 16'h5a5a;
        acks = 0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            tick();
            if (b3.c_ack) acks++;
        end
        rst3 = 1'b1;
        b3.c_req = 1'b0;
        tick();
        ctrl = {b3.rdn_buf, b3.wrn0_buf, b3.wrn1_buf, b3.abus_oen};
        if (b3.c_ack) acks++;
        rst3 = 1'b0;
        n_total++;
        if (ctrl !== 4'b1111) $display("[TB] FAIL abort_ctrl: got %b want 1111", ctrl);
        else n_pass++;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            if (b3.c_ack) acks++;
        end
        n_total++;
        if (acks !== 0) $display("[TB] FAIL abort_no_ack: got %0d want 0", acks);
        else n_pass++;
        sb.push_back('{1'b0, 16'h0010, 16'h0000, 16'h5a5a, 0, 0, 4, 6});
        b3.c_req = 1'b1;
        ack_cyc = -1; cdin = 16'hdead;
        for (int cyc = 1; cyc <= 20 && ack_cyc < 0; cyc++) begin
            tick();
            if (b3.c_ack) begin
                ack_cyc = cyc;
                cdin    = b3.c_din;
            end
        end
        b3.c_req = 1'b0;
        tick();
        begin
            exp_t got;
            got = sb.pop_front();
            n_total++;
            if ({ack_cyc, cdin} !== {got.ack_cyc, got.din}) $display("[TB] FAIL abort_reissue: got cyc=%0d din=%h want cyc=%0d din=%h", ack_cyc, cdin, got.ack_cyc, got.din);
            else n_pass++;
        end
    endtask

    task automatic init_bus();
        b0.c_req = 0; b0.c_wr = 0; b0.c_byte = 0; b0.c_addr = 0; b0.c_dout = 0;
        b0.d_req = 0; b0.d_wr = 0; b0.d_byte = 0; b0.d_addr = 0; b0.d_dout = 0; b0.din = 0;
        b2.c_req = 0; b2.c_wr = 0; b2.c_byte = 0; b2.c_addr = 0; b2.c_dout = 0;
        b2.d_req = 0; b2.d_wr = 0; b2.d_byte = 0; b2.d_addr = 0; b2.d_dout = 0; b2.din = 0;
        b3.c_req = 0; b3.c_wr = 0; b3.c_byte = 0; b3.c_addr = 0; b3.c_dout = 0;
        b3.d_req = 0; b3.d_wr = 0; b3.d_byte = 0; b3.d_addr = 0; b3.d_dout = 0; b3.din = 0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst  = 1'b1;
        rst3 = 1'b1;
        init_bus();
        test_reset();
        test_word_write();
        test_byte_store();
        test_byte_load();
        test_wait_read();
        test_arbitration();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates and sequences the external 16-bit memory bus between two masters: the processor core (port C) and a secondary master such as a loader/debug/DMA engine (port D). It runs the bus cycle itself through a fixed setup/strobe/release state machine, drives the active-low buffer strobes and the address-bus output enable, and handles byte-lane steering for byte loads and stores. It sits between `core` and the external SRAM/IO buffers.

## Interface
- WAIT_STATES, 0, extra STROBE cycles per access (0..15)
- STARVE_LIMIT, 4, consecutive core grants allowed while D waits (1..15; used only with the fairness macro)
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- C_REQ / D_REQ  in  1  access request; held until the matching ACK
- C_WR / D_WR  in  1  1 = write, 0 = read
- C_BYTE / D_BYTE  in  1  1 = byte access, lane selected by ADDR[0]
- C_ADDR / D_ADDR  in  16  byte address
- C_DOUT / D_DOUT  in  16  write data; for byte writes only bits [7:0] are used
- C_DIN / D_DIN  out  16  read data, registered, valid while ACK is high
- C_ACK / D_ACK  out  1  one-cycle completion pulse
- GNT_D  out  1  1 while port D owns the bus (SETUP..DONE)
- ADDR_BUF  out  16  bus address
- DOUT_BUF  out  16  bus write data
- DIN  in  16  bus read data
- RDN_BUF  out  1  read strobe, active low
- WRN0_BUF / WRN1_BUF  out  1  low-/high-byte write strobes, active low
- ABUS_OEN  out  1  address/data buffer enable, active low

## Operation
- States: IDLE, SETUP, STROBE, DONE.
- IDLE: ABUS_OEN=1, all strobes high. If any REQ is high, select the owner, latch its ADDR/WR/BYTE/DOUT into bus registers, and go to SETUP.
- SETUP (1 cycle): ABUS_OEN=0, ADDR_BUF/DOUT_BUF driven, strobes high.
- STROBE (1+WAIT_STATES cycles): RDN_BUF low for reads; for writes, word access pulls both WRN low, byte access pulls WRN1 low if ADDR[0]=1, else WRN0. On the last STROBE cycle, DIN is registered into the owner's DIN output.
- DONE (1 cycle): strobes high, ABUS_OEN=0, address held, owner's ACK=1; then IDLE.
- Byte write: DOUT_BUF = {DOUT[7:0],8'h00} if ADDR[0]=1, otherwise {8'h00,DOUT[7:0]}. Word write: DOUT_BUF = DOUT.
- Byte read: xDIN = {8'h00, DIN[15:8]} if ADDR[0]=1, otherwise {8'h00, DIN[7:0]}. Word read: DIN unchanged. ADDR[0] is passed through on word accesses.
- Arbitration: only in IDLE. If one REQ is high, that port wins. If both are high, the core wins, subject to Configuration. The non-owner's ACK stays 0 and its DIN output is unchanged.
- Requester rule: hold REQ and its qualifiers stable until ACK is seen, then drop REQ on that edge. A REQ still high in IDLE is a new access.

## Timing
- Reset values: state IDLE; ADDR_BUF=0, DOUT_BUF=0, C_DIN=D_DIN=0, RDN_BUF=WRN0_BUF=WRN1_BUF=1, ABUS_OEN=1, C_ACK=D_ACK=0, GNT_D=0, starvation counter=0.
- Latency: REQ is sampled in IDLE at edge n. ACK is high during cycle n+3+WAIT_STATES. Back-to-back throughput is one access per 4+WAIT_STATES cycles.
- Strobes never go low in SETUP or DONE, so the address is stable at least one cycle before and after every strobe.
- Reset during an access takes effect at the next edge: state returns to IDLE, strobes and ABUS_OEN go high, and no ACK is issued. Requesters re-issue the access.
- REQ dropped before ACK: the access completes and ACK still pulses. Behaviour is defined, but the requester must ignore it.

## Configuration
- MEMARB_FAIRNESS_EN defined:
  - A 4-bit counter increments on each core grant made while D_REQ is high.
  - When the counter equals STARVE_LIMIT and both ports request, D wins and the counter clears.
  - Any D grant clears the counter.
- MEMARB_FAIRNESS_EN undefined: fixed core priority, no counter. D can starve indefinitely.

## Test plan
- Core word write, WAIT_STATES=0, C_ADDR=0xfaaf, C_DOUT=0xffaf -> ADDR_BUF=0xfaaf; DOUT_BUF=0xffaf; WRN0_BUF and WRN1_BUF low for exactly 1 cycle; C_ACK 3 cycles after REQ sample.
- Core byte stores, data 0x0035 -> at 0x1001: DOUT_BUF=0x3500, only WRN1_BUF low. At 0x1000: DOUT_BUF=0x0035, only WRN0_BUF low.
- Core byte loads with DIN=0x3579 -> at 0x1001: C_DIN=0x0035. At 0x1000: C_DIN=0x0079. Word load at 0x1000: C_DIN=0x3579.
- WAIT_STATES=2, D read at 0x0024 -> RDN_BUF low 3 cycles; GNT_D=1 from SETUP to DONE; D_ACK 5 cycles after sample; C_ACK stays 0.
- Both REQ held continuously, STARVE_LIMIT=4 -> with MEMARB_FAIRNESS_EN: grant sequence C,C,C,C,D,C,C,C,C,D. Without it: only C is granted.
- RESET asserted during the second STROBE cycle with WAIT_STATES=3 -> at the next edge all strobes=1, ABUS_OEN=1, no ACK; a re-issued request completes normally.
